// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin arbiter sharing one down-counting timer between NREQ requesters
module timer_arbiter #(
   parameter int NREQ = 4,
   parameter int CW   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CW-1:0]   dur,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic [CW-1:0]        cnt,
   output logic [NREQ-1:0]      done
);

   localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [IW-1:0]   owner_q;
   logic [IW-1:0]   ptr_q;
   logic [NREQ-1:0] gnt_q;
   logic            busy_q;
   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] done_q;

   logic [IW:0]     cand;
   logic [IW-1:0]   sel_d;
   logic            sel_vld_d;
   logic [NREQ-1:0] sel_oh_d;
   logic [CW-1:0]   sel_dur_d;
   logic [NREQ-1:0] own_oh;

   // Round-robin pick: first requester set when scanning ptr+1, ptr+2, ... wrapping at NREQ
   always_comb begin
      cand      = '0;
      sel_d     = '0;
      sel_vld_d = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= (IW+1)'(NREQ)) begin
            cand = cand - (IW+1)'(NREQ);
         end
         if (!sel_vld_d && req[cand[IW-1:0]]) begin
            sel_d     = cand[IW-1:0];
            sel_vld_d = 1'b1;
         end
      end
   end

   // Duration and one-hot of the winner, plus one-hot of the current owner
   always_comb begin
      sel_oh_d  = NREQ'(1) << sel_d;
      sel_dur_d = dur[sel_d*CW +: CW];
      own_oh    = NREQ'(1) << owner_q;
   end

   // Grant / count / complete sequencing; every output is a register updated on the falling edge
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         ptr_q   <= IW'(NREQ-1);
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         done_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (sel_vld_d) begin
                  owner_q <= sel_d;
                  gnt_q   <= sel_oh_d;
                  busy_q  <= 1'b1;
                  cnt_q   <= sel_dur_d;
                  // A zero-length run completes in the grant cycle itself
                  if (sel_dur_d == '0) begin
                     done_q  <= sel_oh_d;
                     state_q <= S_DONE;
                  end else begin
                     done_q  <= '0;
                     state_q <= S_RUN;
                  end
               end else begin
                  gnt_q  <= '0;
                  busy_q <= 1'b0;
                  cnt_q  <= '0;
                  done_q <= '0;
               end
            end

            S_RUN: begin
               done_q <= '0;
               // Losing the request beats reaching terminal count: no completion is reported
               if (!req[owner_q]) begin
                  state_q <= S_IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  ptr_q   <= owner_q;
               end else if (cnt_q <= CW'(1)) begin
                  // Terminal count; the <= guard also keeps the counter from ever wrapping
                  cnt_q   <= '0;
                  done_q  <= own_oh;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end

            S_DONE: begin
               // Completion always lasts exactly one cycle, regardless of req
               state_q <= S_IDLE;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               done_q  <= '0;
               ptr_q   <= owner_q;
            end

            default: begin
               state_q <= S_IDLE;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               done_q  <= '0;
            end
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign busy = busy_q;
   assign cnt  = cnt_q;
   assign done = done_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - scoreboard bench for timer_arbiter
module tb_timer_arbiter;

   localparam int NREQ = 4;
   localparam int CW   = 8;

   logic                clk;
   logic                reset;
   logic [NREQ-1:0]     req;
   logic [NREQ*CW-1:0]  dur;
   logic [NREQ-1:0]     gnt;
   logic                busy;
   logic [CW-1:0]       cnt;
   logic [NREQ-1:0]     done;

   typedef struct {
      string      tag;
      logic [3:0] gnt;
      logic       busy;
      logic [7:0] cnt;
      logic [3:0] done;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .dur   (dur),
      .gnt   (gnt),
      .busy  (busy),
      .cnt   (cnt),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] g, input logic b,
                       input logic [7:0] c, input logic [3:0] d);
      exp_t e;
      e.tag  = tag;
      e.gnt  = g;
      e.busy = b;
      e.cnt  = c;
      e.done = d;
      exp_q.push_back(e);
   endtask

   // Expected per-edge outputs of one complete run of length d granted to one-hot g
   task automatic exp_run(input string tag, input logic [3:0] g, input int d);
      if (d == 0) begin
         push(tag, g, 1'b1, 8'd0, g);
      end else begin
         for (int j = d; j >= 1; j--) push(tag, g, 1'b1, 8'(j), 4'b0000);
         push(tag, g, 1'b1, 8'd0, g);
      end
      push(tag, 4'b0000, 1'b0, 8'd0, 4'b0000);
   endtask

   // Sample on the rising edge, half a period after the active falling edge
   task automatic run_n(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".gnt"},  32'(gnt),  32'(e.gnt));
            chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
            chk({e.tag, ".cnt"},  32'(cnt),  32'(e.cnt));
            chk({e.tag, ".done"}, 32'(done), 32'(e.done));
         end
      end
   endtask

   initial begin
      int order[6];
      order = '{0, 1, 2, 3, 0, 1};

      reset = 1'b1;
      req   = 4'b1111;
      dur   = 32'h02020202;
      #1 reset = 1'b0;

      // Held in reset with every requester asking
      push("in_reset", 4'b0000, 1'b0, 8'd0, 4'b0000);
      push("in_reset", 4'b0000, 1'b0, 8'd0, 4'b0000);
      run_n(2);

      // Release: requester 0 wins first; drop req during DONE has no effect
      reset = 1'b1;
      exp_run("rst_rel", 4'b0001, 2);
      run_n(3);
      req = 4'b0000;
      run_n(1);
      push("idle", 4'b0000, 1'b0, 8'd0, 4'b0000);
      run_n(1);

      // Single request D=3; dur changed after grant must be ignored
      req = 4'b0010;
      dur[15:8] = 8'd3;
      exp_run("single", 4'b0010, 3);
      run_n(1);
      dur[15:8] = 8'd9;
      run_n(4);
      req = 4'b0000;

      // Zero duration
      req = 4'b0100;
      dur[23:16] = 8'd0;
      exp_run("zero", 4'b0100, 0);
      run_n(2);
      req = 4'b0000;

      // Abort when cnt reads 3, then requester 3 is served
      req = 4'b0100;
      dur[23:16] = 8'd5;
      push("abort_run", 4'b0100, 1'b1, 8'd5, 4'b0000);
      push("abort_run", 4'b0100, 1'b1, 8'd4, 4'b0000);
      push("abort_run", 4'b0100, 1'b1, 8'd3, 4'b0000);
      run_n(3);
      req = 4'b0000;
      push("abort_drop", 4'b0000, 1'b0, 8'd0, 4'b0000);
      run_n(1);
      req = 4'b1000;
      dur[31:24] = 8'd1;
      exp_run("after_abort", 4'b1000, 1);
      run_n(3);
      req = 4'b0000;

      // Round robin, all requesting, every duration 1
      dur = 32'h01010101;
      req = 4'b1111;
      for (int i = 0; i < 6; i++) exp_run("rr", 4'(1) << order[i], 1);
      run_n(18);
      req = 4'b0000;

      // Async reset while cnt reads 4
      req = 4'b0001;
      dur[7:0] = 8'd6;
      push("async_run", 4'b0001, 1'b1, 8'd6, 4'b0000);
      push("async_run", 4'b0001, 1'b1, 8'd5, 4'b0000);
      push("async_run", 4'b0001, 1'b1, 8'd4, 4'b0000);
      run_n(3);
      #2 reset = 1'b0;
      #1;
      chk("async.gnt",  32'(gnt),  32'd0);
      chk("async.busy", 32'(busy), 32'd0);
      chk("async.cnt",  32'(cnt),  32'd0);
      chk("async.done", 32'(done), 32'd0);
      #1 reset = 1'b1;
      req = 4'b1010;
      dur[15:8] = 8'd2;
      exp_run("post_rst", 4'b0010, 2);
      run_n(4);
      req = 4'b0000;
      push("final_idle", 4'b0000, 1'b0, 8'd0, 4'b0000);
      run_n(1);

      chk("sb_left", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
